execute: RTL and testbench
==========================

// Module: execute
// PURPOSE
//  Execute stage of the CPU pipeline, directly downstream of the read stage.
//  - Consumes read-stage outputs: operands, ALU controls, shift offset and PC controls.
//  - Computes the ALU result and the Z/C/N/V flags.
//  - Resolves the next-PC target.
//  - Stalls the read stage while an iterative (bit-serial) shift is in progress.
// PARAMETERS
//  DATA_W  16  operand/result width
//  PC_W    31  program counter width
//  SH_W    4   shift offset width (max shift = 2**SH_W-1)
// PORTS
//  cpu_clk        in   1       pipeline clock; all state updates on rising edge
//  cpu_rst        in   1       synchronous, active-high reset
//  i_alu_en       in   1       read stage presents a valid op this cycle
//  i_alu_op       in   5       operation code (see BEHAVIOUR)
//  i_truth_table  in   4       LOGIC op table, indexed {a_bit,b_bit}
//  sh_off         in   SH_W    shift/rotate amount
//  src_a_en       in   1       src_a valid; when 0, operand A is taken as 0
//  src_a          in   DATA_W  operand A
//  src_b_en       in   1       src_b valid; when 0, operand B is taken as 0
//  src_b          in   DATA_W  operand B
//  i_pc_set       in   1       absolute jump to the result
//  i_pc_add       in   1       relative jump by the sign-extended result
//  i_pc_inc       in   1       sequential advance
//  pc             in   PC_W    PC of the instruction
//  stall          out  1       read stage must hold all inputs while high
//  result_valid   out  1       one-cycle pulse: result/flags/pc outputs valid
//  result         out  DATA_W  ALU result
//  o_flags        out  4       {Z,C,N,V}; persistent, updated only on result_valid
//  o_pc_load      out  1       one-cycle pulse with result_valid when a PC op is active
//  o_pc_target    out  PC_W    next PC
// BEHAVIOUR
//  - Reset: FSM->IDLE; stall, result_valid, o_pc_load = 0.
//    result, o_flags, o_pc_target = 0. Any shift in progress is aborted.
//  - Accept: op accepted at a rising edge where i_alu_en=1, stall=0 and cpu_rst=0.
//  - Opcodes:
//      00 LOGIC  r[i] = i_truth_table[{a[i],b[i]}]
//      01 ADD, 02 SUB (a-b), 03 ADC, 04 SBC (borrow = ~C)
//      05 SHL, 06 SHR, 07 SAR, 08 ROL, 09 ROR   (operand A by sh_off)
//      0A PASSB (r = b)
//      other: r = 0, flags unchanged
//  - Arithmetic:
//      DATA_W+1-bit sum. C = carry out; SUB/SBC C = no-borrow.
//      V = signed overflow. Z = (r==0). N = r[DATA_W-1].
//      Logic/PASSB: C and V unchanged. Shifts: C = last bit shifted out (unchanged if sh_off=0), V = 0.
//  - Single-cycle ops, latency 1: accepted at edge E -> result_valid=1 for the cycle after E.
//  - Iterative shifts: FSM IDLE -> SHIFT -> IDLE.
//      - sh_off=0: behaves as a single-cycle op (r = a).
//      - sh_off=k>0: edge E loads shift reg and counter = k, enters SHIFT.
//      - stall=1 while in SHIFT; one bit per edge.
//      - result_valid after edge E+k; FSM returns to IDLE on that same edge.
//      - Further ops accepted no earlier than edge E+k (stall is low again by then).
//      - i_alu_en is ignored while stall=1; the read stage holds its outputs.
//  - PC, evaluated on completion; priority set > add > inc:
//      set -> {(PC_W-DATA_W)'0, r}
//      add -> pc + sext(r)       (wraps mod 2**PC_W)
//      inc -> pc + 1             (pc=all-ones wraps to 0)
//      none -> o_pc_load = 0, o_pc_target holds.
//  - Back-to-back: single-cycle ops may be accepted every cycle; result_valid stays high.
// CONFIGURATION
//  - BARREL_SHIFT_EN defined: all shifts/rotates complete in 1 cycle.
//      SHIFT state is removed and stall is tied to 0.
//  - BARREL_SHIFT_EN undefined: iterative shifter as described, latency max(1, sh_off).
//  - Results and flags are identical in both builds.
// TESTING
//  1. ADD a=0xFFFF b=0x0001 -> result=0x0000, flags Z=1 C=1 N=0 V=0, 1-cycle latency.
//  2. SUB a=0x8000 b=0x0001 -> result=0x7FFF, C=1 V=1 N=0; then SBC 5-3 with C=1 -> 0x0002.
//  3. LOGIC tt=4'b0110 a=0x00FF b=0x0F0F -> result=0x0FF0 (XOR), C/V unchanged.
//  4. SHR a=0x8001 sh_off=3 -> stall high 3 cycles, result_valid 3 cycles after accept,
//     result=0x1000, C=0; with BARREL_SHIFT_EN same result at latency 1, stall=0.
//  5. PASSB b=0xFFFE, i_pc_add=1 i_pc_inc=1 pc=0x10 -> o_pc_load=1, o_pc_target=0x0E.
//     Then i_pc_inc with pc=0x7FFFFFFF -> target 0.
//  6. cpu_rst asserted mid-ROL (sh_off=10, after 4 cycles)
//     -> next cycle stall=0, result_valid=0, result=0, o_flags=0; new op accepted next edge.

Source files
------------

// File: rtl/execute.sv
// Execute stage: ALU with Z/C/N/V flags, next-PC resolution and a bit-serial shifter that stalls the read stage.
// Define BARREL_SHIFT_EN to replace the bit-serial shifter with a single-cycle barrel shifter (stall tied low).
module execute #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 31,
   parameter int SH_W   = 4
) (
   input  logic              cpu_clk,
   input  logic              cpu_rst,
   input  logic              i_alu_en,
   input  logic [4:0]        i_alu_op,
   input  logic [3:0]        i_truth_table,
   input  logic [SH_W-1:0]   sh_off,
   input  logic              src_a_en,
   input  logic [DATA_W-1:0] src_a,
   input  logic              src_b_en,
   input  logic [DATA_W-1:0] src_b,
   input  logic              i_pc_set,
   input  logic              i_pc_add,
   input  logic              i_pc_inc,
   input  logic [PC_W-1:0]   pc,
   output logic              stall,
   output logic              result_valid,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        o_flags,
   output logic              o_pc_load,
   output logic [PC_W-1:0]   o_pc_target,
   output logic              fsm_state
);
   localparam logic [4:0] OP_LOGIC = 5'h00, OP_ADD = 5'h01, OP_SUB = 5'h02, OP_ADC = 5'h03,
                          OP_SBC = 5'h04, OP_SHL = 5'h05, OP_SHR = 5'h06, OP_SAR = 5'h07,
                          OP_ROL = 5'h08, OP_ROR = 5'h09, OP_PASSB = 5'h0A;

   // Handshake: an op is taken on a rising edge with i_alu_en=1 and stall=0; while stall=1 the
   // read stage holds every input stable, so op, pc and PC controls are read directly at completion.

   logic [DATA_W-1:0] a, b, r, bx, sh_val;
   logic [DATA_W:0]   sum;
   logic              sh_c, c, v, cin, upd, accept, complete, pc_hit;
   logic [3:0]        new_flags;
   logic [PC_W-1:0]   pc_next;

   assign a      = src_a_en ? src_a : '0;
   assign b      = src_b_en ? src_b : '0;
   assign accept = i_alu_en && !stall;

   // One shift step: returns {bit shifted out, shifted value}.
   function automatic logic [DATA_W:0] shift_step(input logic [4:0] op, input logic [DATA_W-1:0] x);
      case (op)
         OP_SHL:  shift_step = {x[DATA_W-1], x[DATA_W-2:0], 1'b0};
         OP_SHR:  shift_step = {x[0], 1'b0, x[DATA_W-1:1]};
         OP_SAR:  shift_step = {x[0], x[DATA_W-1], x[DATA_W-1:1]};
         OP_ROL:  shift_step = {x[DATA_W-1], x[DATA_W-2:0], x[DATA_W-1]};
         OP_ROR:  shift_step = {x[0], x[0], x[DATA_W-1:1]};
         default: shift_step = {1'b0, x};
      endcase
   endfunction

`ifdef BARREL_SHIFT_EN
   assign stall     = 1'b0;
   assign fsm_state = 1'b0;
   assign complete  = accept;

   always_comb begin
      sh_val = a;
      sh_c   = o_flags[2];
      for (int i = 0; i < (1 << SH_W) - 1; i++)
         if (i < int'(sh_off)) {sh_c, sh_val} = shift_step(i_alu_op, sh_val);
   end
`else
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
   state_t            state, next_state;
   logic [DATA_W-1:0] sh_reg;
   logic [SH_W-1:0]   sh_cnt;
   logic              load, is_shift;

   assign stall     = (state == SHIFT);
   assign fsm_state = state;
   assign is_shift  = (i_alu_op >= OP_SHL) && (i_alu_op <= OP_ROR);

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_shift && sh_off != '0) begin
                  load       = 1'b1;
                  next_state = SHIFT;
               end else begin
                  complete = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (sh_cnt == SH_W'(1)) begin
               complete   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outside SHIFT a zero-length shift passes A through with carry untouched.
   always_comb begin
      sh_val = a;
      sh_c   = o_flags[2];
      if (state == SHIFT) {sh_c, sh_val} = shift_step(i_alu_op, sh_reg);
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         sh_reg <= '0;
         sh_cnt <= '0;
      end else if (load) begin
         sh_reg <= a;
         sh_cnt <= sh_off;
      end else if (state == SHIFT) begin
         sh_reg <= sh_val;
         sh_cnt <= sh_cnt - SH_W'(1);
      end
   end
`endif

   always_comb begin
      r   = '0;
      c   = o_flags[2];
      v   = o_flags[0];
      upd = 1'b1;
      bx  = b;
      cin = 1'b0;
      sum = '0;
      case (i_alu_op)
         OP_LOGIC: for (int i = 0; i < DATA_W; i++) r[i] = i_truth_table[{a[i], b[i]}];
         OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
            // Subtraction is a + ~b + carry-in; SBC borrow is ~C, so its carry-in is C itself.
            bx  = (i_alu_op == OP_SUB || i_alu_op == OP_SBC) ? ~b : b;
            cin = (i_alu_op == OP_SUB) ? 1'b1 : (i_alu_op == OP_ADD) ? 1'b0 : o_flags[2];
            sum = {1'b0, a} + {1'b0, bx} + {{DATA_W{1'b0}}, cin};
            r   = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            v   = (a[DATA_W-1] == bx[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         end
         OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
            r = sh_val;
            c = sh_c;
            v = 1'b0;
         end
         OP_PASSB: r = b;
         default:  upd = 1'b0;
      endcase
      new_flags = upd ? {r == '0, c, r[DATA_W-1], v} : o_flags;
   end

   always_comb begin
      pc_next = o_pc_target;
      pc_hit  = 1'b1;
      if (i_pc_set)      pc_next = {{(PC_W-DATA_W){1'b0}}, r};
      else if (i_pc_add) pc_next = pc + {{(PC_W-DATA_W){r[DATA_W-1]}}, r};
      else if (i_pc_inc) pc_next = pc + PC_W'(1);
      else               pc_hit  = 1'b0;
   end

   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         result_valid <= 1'b0;
         o_pc_load    <= 1'b0;
         result       <= '0;
         o_flags      <= '0;
         o_pc_target  <= '0;
      end else begin
         result_valid <= complete;
         o_pc_load    <= complete && pc_hit;
         if (complete) begin
            result      <= r;
            o_flags     <= new_flags;
            o_pc_target <= pc_next;
         end
      end
   end
endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: hand-computed vectors for ALU ops, flags, shifts, PC and reset abort.
module tb_execute;
   logic        cpu_clk, cpu_rst;
   logic        i_alu_en;
   logic [4:0]  i_alu_op;
   logic [3:0]  i_truth_table;
   logic [3:0]  sh_off;
   logic        src_a_en, src_b_en;
   logic [15:0] src_a, src_b;
   logic        i_pc_set, i_pc_add, i_pc_inc;
   logic [30:0] pc;
   logic        stall, result_valid, o_pc_load, fsm_state;
   logic [15:0] result;
   logic [3:0]  o_flags;
   logic [30:0] o_pc_target;

   int n_checks = 0;
   int n_errors = 0;

`ifdef BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   execute dut (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .i_alu_en(i_alu_en), .i_alu_op(i_alu_op),
      .i_truth_table(i_truth_table), .sh_off(sh_off), .src_a_en(src_a_en), .src_a(src_a),
      .src_b_en(src_b_en), .src_b(src_b), .i_pc_set(i_pc_set), .i_pc_add(i_pc_add),
      .i_pc_inc(i_pc_inc), .pc(pc), .stall(stall), .result_valid(result_valid),
      .result(result), .o_flags(o_flags), .o_pc_load(o_pc_load), .o_pc_target(o_pc_target),
      .fsm_state(fsm_state)
   );

   initial cpu_clk = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge cpu_clk);
      #1;
   endtask

   // Present one op and let it be accepted; caller decides whether i_alu_en stays high.
   task automatic op1(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] tt, input logic [2:0] pcc, input logic [30:0] pcv);
      i_alu_en      = 1'b1;
      i_alu_op      = op;
      src_a         = a;
      src_b         = b;
      i_truth_table = tt;
      sh_off        = 4'd0;
      {i_pc_set, i_pc_add, i_pc_inc} = pcc;
      pc            = pcv;
      step();
   endtask

   task automatic expect_res(input string tag, input logic [15:0] r, input logic [3:0] f);
      check({tag, "_valid"}, result_valid, 1);
      check({tag, "_result"}, result, r);
      check({tag, "_flags"}, o_flags, f);
   endtask

   task automatic run_shift(input string tag, input logic [4:0] op, input logic [15:0] a,
                            input logic [3:0] sh, input logic [15:0] er, input logic [3:0] ef);
      int lat, stalls, exp_lat;
      exp_lat = BARREL ? 0 : int'(sh);
      op1(op, a, 16'h0000, 4'h0, 3'b000, 31'd0);
      sh_off = sh;
      lat    = 0;
      stalls = 0;
      // sh_off must be valid at the accepting edge, so re-present it before that edge
      if (1'b1) begin end
      while (!result_valid && lat < 40) begin
         if (stall) stalls++;
         step();
         lat++;
      end
      i_alu_en = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_stall_cycles"}, stalls, exp_lat);
      check({tag, "_stall_end"}, stall, 0);
      expect_res(tag, er, ef);
   endtask

   // Shift ops need sh_off at the accept edge, so they are presented here instead of via op1.
   task automatic shift_op(input string tag, input logic [4:0] op, input logic [15:0] a,
                           input logic [3:0] sh, input logic [15:0] er, input logic [3:0] ef);
      int lat, stalls, exp_lat;
      exp_lat       = BARREL ? 0 : int'(sh);
      i_alu_en      = 1'b1;
      i_alu_op      = op;
      src_a         = a;
      src_b         = 16'h0;
      sh_off        = sh;
      {i_pc_set, i_pc_add, i_pc_inc} = 3'b000;
      step();
      lat    = 0;
      stalls = 0;
      while (!result_valid && lat < 40) begin
         if (stall) stalls++;
         step();
         lat++;
      end
      i_alu_en = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_stall_cycles"}, stalls, exp_lat);
      check({tag, "_stall_end"}, stall, 0);
      expect_res(tag, er, ef);
   endtask

   initial begin
      cpu_rst = 1'b1; i_alu_en = 1'b0; i_alu_op = 5'h0; i_truth_table = 4'h0; sh_off = 4'h0;
      src_a_en = 1'b1; src_b_en = 1'b1; src_a = 16'h0; src_b = 16'h0;
      i_pc_set = 1'b0; i_pc_add = 1'b0; i_pc_inc = 1'b0; pc = 31'h0;
      repeat (3) step();
      check("rst_stall", stall, 0);
      check("rst_valid", result_valid, 0);
      check("rst_result", result, 0);
      check("rst_flags", o_flags, 0);
      check("rst_pc_load", o_pc_load, 0);
      check("rst_pc_target", o_pc_target, 0);
      cpu_rst = 1'b0;

      // Back-to-back single-cycle ops; flags are {Z,C,N,V}
      op1(5'h01, 16'hFFFF, 16'h0001, 4'h0, 3'b000, 31'd0);
      expect_res("add_wrap", 16'h0000, 4'b1100);
      check("add_pc_load", o_pc_load, 0);
      op1(5'h03, 16'h0001, 16'h0001, 4'h0, 3'b000, 31'd0);
      expect_res("adc_cin", 16'h0003, 4'b0000);
      op1(5'h02, 16'h8000, 16'h0001, 4'h0, 3'b000, 31'd0);
      expect_res("sub_ovf", 16'h7FFF, 4'b0101);
      op1(5'h00, 16'h00FF, 16'h0F0F, 4'b0110, 3'b000, 31'd0);
      expect_res("logic_xor", 16'h0FF0, 4'b0101);
      op1(5'h04, 16'h0005, 16'h0003, 4'h0, 3'b000, 31'd0);
      expect_res("sbc_c1", 16'h0002, 4'b0100);
      i_alu_en = 1'b0;
      step();
      check("idle_valid", result_valid, 0);

      shift_op("shr3", 5'h06, 16'h8001, 4'd3, 16'h1000, 4'b0000);
      shift_op("shl1", 5'h05, 16'h8001, 4'd1, 16'h0002, 4'b0100);
      shift_op("sar4", 5'h07, 16'h8000, 4'd4, 16'hF800, 4'b0010);
      shift_op("ror1", 5'h09, 16'h0001, 4'd1, 16'h8000, 4'b0110);
      shift_op("shl0", 5'h05, 16'h1234, 4'd0, 16'h1234, 4'b0100);

      op1(5'h1F, 16'h1234, 16'h5678, 4'h0, 3'b000, 31'd0);
      expect_res("bad_op", 16'h0000, 4'b0100);

      op1(5'h0A, 16'h0000, 16'hFFFE, 4'h0, 3'b011, 31'h10);
      expect_res("passb_add", 16'hFFFE, 4'b0110);
      check("pc_add_load", o_pc_load, 1);
      check("pc_add_target", o_pc_target, 31'h0E);
      op1(5'h01, 16'h0001, 16'h0001, 4'h0, 3'b000, 31'h55);
      check("pc_none_load", o_pc_load, 0);
      check("pc_none_hold", o_pc_target, 31'h0E);
      src_b_en = 1'b0;
      op1(5'h01, 16'h0005, 16'h0009, 4'h0, 3'b000, 31'h0);
      expect_res("src_b_off", 16'h0005, 4'b0000);
      src_b_en = 1'b1;
      op1(5'h0A, 16'h0000, 16'h0007, 4'h0, 3'b001, 31'h7FFFFFFF);
      check("pc_inc_load", o_pc_load, 1);
      check("pc_inc_wrap", o_pc_target, 31'h0);
      op1(5'h0A, 16'h0000, 16'h8234, 4'h0, 3'b101, 31'h40);
      expect_res("pc_set", 16'h8234, 4'b0010);
      check("pc_set_target", o_pc_target, 31'h8234);
      i_alu_en = 1'b0;
      step();

      // Reset in the middle of a long rotate
      i_alu_en = 1'b1; i_alu_op = 5'h08; src_a = 16'h0001; sh_off = 4'd10;
      {i_pc_set, i_pc_add, i_pc_inc} = 3'b000;
      step();
      repeat (4) step();
      check("rol_mid_stall", stall, BARREL ? 0 : 1);
      check("rol_mid_state", fsm_state, BARREL ? 0 : 1);
      cpu_rst = 1'b1;
      step();
      check("abort_stall", stall, 0);
      check("abort_valid", result_valid, 0);
      check("abort_result", result, 0);
      check("abort_flags", o_flags, 0);
      cpu_rst = 1'b0;
      op1(5'h01, 16'h0002, 16'h0003, 4'h0, 3'b000, 31'h0);
      expect_res("post_rst_add", 16'h0005, 4'b0000);
      i_alu_en = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
